// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller: command encodings,
// controller state codes, default widths and a command decoder.
package timer_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int PRESC_W_DEF = 8;

  localparam logic [1:0] CMD_LOAD  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic load;
    logic start;
    logic stop;
    logic clear;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic valid, input logic [1:0] op);
    cmd_dec_t d;
    d.load  = valid && (op == CMD_LOAD);
    d.start = valid && (op == CMD_START);
    d.stop  = valid && (op == CMD_STOP);
    d.clear = valid && (op == CMD_CLEAR);
    return d;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock-enable divider: hit is high every div+1 enabled cycles; tick is the
// registered copy of hit, so it lines up with the count update it caused.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               hit,
  output logic [PRESC_W-1:0] cnt,
  output logic               tick
);

  assign hit = en && (cnt == div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= hit;
      if (clr || hit)
        cnt <= '0;
      else if (en)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: LOAD/START/STOP/CLEAR sequencing, one-shot and
// periodic modes, expire pulse and sticky irq. Optional capture port under
// the TIMER_CTRL_CAPTURE_EN macro.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [CNT_W-1:0]   cmd_data,
  input  logic               periodic,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               tick,
  output logic               expire,
  output logic               irq
`ifdef TIMER_CTRL_CAPTURE_EN
  ,
  input  logic               cap_req,
  output logic [CNT_W-1:0]   cap_val,
  output logic               cap_valid
`endif
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   reload;
  logic               mode_q;
  logic [PRESC_W-1:0] div_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic               hit;
  cmd_dec_t           cmd;
  logic               run;
  logic               start_new;
  logic               resume;
  logic               pause;
  logic               presc_en;
  logic               terminal;

  assign cmd       = decode_cmd(cmd_valid, cmd_op);
  assign run       = (state == ST_RUN);
  assign start_new = cmd.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign resume    = cmd.start && (state == ST_PAUSE);
  assign pause     = cmd.stop && run;
  // A STOP in the tick cycle freezes the prescaler so the tick is dropped.
  assign presc_en  = run && !cmd.stop;
  assign terminal  = hit && (count == '0);
  assign busy      = run;

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (start_new),
    .div   (div_q),
    .hit   (hit),
    .cnt   (presc_cnt),
    .tick  (tick)
  );

  // NOTE: sequential state uses non-blocking assignments so every branch sees
  // the pre-edge values (e.g. a LOAD and a periodic reload in one cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      reload <= '0;
      count  <= '0;
      mode_q <= 1'b0;
      div_q  <= '0;
      expire <= 1'b0;
      irq    <= 1'b0;
    end else begin
      expire <= terminal;

      if (cmd.load)
        reload <= cmd_data;

      if (terminal)
        irq <= 1'b1;
      else if (cmd.clear)
        irq <= 1'b0;

      if (start_new) begin
        count  <= reload;
        mode_q <= periodic;
        div_q  <= presc_div;
        state  <= ST_RUN;
      end else if (resume) begin
        state <= ST_RUN;
      end else if (pause) begin
        state <= ST_PAUSE;
      end else if (hit) begin
        if (count != '0)
          count <= count - 1'b1;
        else if (mode_q)
          count <= reload;
        else
          state <= ST_DONE;
      end
    end
  end

`ifdef TIMER_CTRL_CAPTURE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_val   <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= cap_req;
      if (cap_req)
        cap_val <= count;
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl; capture test is compiled in
// when TIMER_CTRL_CAPTURE_EN is defined.
module tb_timer_ctrl;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_data = '0;
  logic        periodic = 1'b0;
  logic [7:0]  presc_div = '0;
  logic [15:0] count;
  logic        busy, tick, expire, irq;
`ifdef TIMER_CTRL_CAPTURE_EN
  logic        cap_req = 1'b0;
  logic [15:0] cap_val;
  logic        cap_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.CNT_W(16), .PRESC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .periodic  (periodic),
    .presc_div (presc_div),
    .count     (count),
    .busy      (busy),
    .tick      (tick),
    .expire    (expire),
    .irq       (irq)
`ifdef TIMER_CTRL_CAPTURE_EN
    ,
    .cap_req   (cap_req),
    .cap_val   (cap_val),
    .cap_valid (cap_valid)
`endif
  );

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cycles(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    cycles(2);
    reset = 1'b1;
    cycles(3);
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    n_checks++; if (expire !== 1'b0) begin n_fail++; $display("FAIL reset_expire got %b want 0", expire); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
  endtask

  task automatic test_periodic();
    do_reset();
    periodic  = 1'b1;
    presc_div = 8'd1;
    send_cmd(CMD_LOAD, 16'd3);
    send_cmd(CMD_START, 16'd0);
    n_checks++; if (count !== 16'd3) begin n_fail++; $display("FAIL per_start_count got %0d want 3", count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL per_start_busy got %b want 1", busy); end
    for (int k = 1; k <= 16; k++) begin
      logic [15:0] exp_cnt;
      logic        exp_exp;
      logic        exp_tick;
      cycles(1);
      exp_cnt  = 16'(3 - ((k % 8) / 2));
      exp_exp  = ((k % 8) == 0);
      exp_tick = ((k % 2) == 0);
      n_checks++; if (count !== exp_cnt) begin n_fail++; $display("FAIL per_count k=%0d got %0d want %0d", k, count, exp_cnt); end
      n_checks++; if (expire !== exp_exp) begin n_fail++; $display("FAIL per_expire k=%0d got %b want %b", k, expire, exp_exp); end
      n_checks++; if (tick !== exp_tick) begin n_fail++; $display("FAIL per_tick k=%0d got %b want %b", k, tick, exp_tick); end
    end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL per_irq got %b want 1", irq); end
  endtask

  task automatic test_oneshot();
    do_reset();
    periodic  = 1'b0;
    presc_div = 8'd0;
    send_cmd(CMD_LOAD, 16'd2);
    send_cmd(CMD_START, 16'd0);
    n_checks++; if (count !== 16'd2) begin n_fail++; $display("FAIL os_k0_count got %0d want 2", count); end
    cycles(1);
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL os_k1_count got %0d want 1", count); end
    cycles(1);
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL os_k2_count got %0d want 0", count); end
    n_checks++; if (expire !== 1'b0) begin n_fail++; $display("FAIL os_k2_expire got %b want 0", expire); end
    cycles(1);
    n_checks++; if (expire !== 1'b1) begin n_fail++; $display("FAIL os_k3_expire got %b want 1", expire); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL os_k3_busy got %b want 0", busy); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL os_k3_irq got %b want 1", irq); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL os_k3_count got %0d want 0", count); end
    cycles(1);
    n_checks++; if (expire !== 1'b0) begin n_fail++; $display("FAIL os_k4_expire got %b want 0", expire); end
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL os_done_count got %0d want 0", count); end
    send_cmd(CMD_CLEAR, 16'd0);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL os_clear_irq got %b want 0", irq); end
  endtask

  task automatic test_stop_tick();
    do_reset();
    periodic  = 1'b0;
    presc_div = 8'd1;
    send_cmd(CMD_LOAD, 16'd6);
    send_cmd(CMD_START, 16'd0);
    cycles(3);
    n_checks++; if (count !== 16'd5) begin n_fail++; $display("FAIL stop_pre_count got %0d want 5", count); end
    send_cmd(CMD_STOP, 16'd0);
    n_checks++; if (count !== 16'd5) begin n_fail++; $display("FAIL stop_count got %0d want 5", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b want 0", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL stop_tick got %b want 0", tick); end
    cycles(4);
    n_checks++; if (count !== 16'd5) begin n_fail++; $display("FAIL pause_count got %0d want 5", count); end
    send_cmd(CMD_START, 16'd0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resume_busy got %b want 1", busy); end
    n_checks++; if (count !== 16'd5) begin n_fail++; $display("FAIL resume_count got %0d want 5", count); end
    cycles(1);
    n_checks++; if (count !== 16'd4) begin n_fail++; $display("FAIL resume_dec got %0d want 4", count); end
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick got %b want 1", tick); end
  endtask

  task automatic test_load_midrun();
    logic [15:0] exp_seq [4] = '{16'd0, 16'd1, 16'd0, 16'd1};
    logic        exp_ex  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    periodic  = 1'b1;
    presc_div = 8'd0;
    send_cmd(CMD_LOAD, 16'd4);
    send_cmd(CMD_START, 16'd0);
    cycles(2);
    n_checks++; if (count !== 16'd2) begin n_fail++; $display("FAIL lm_pre_count got %0d want 2", count); end
    send_cmd(CMD_LOAD, 16'd1);
    n_checks++; if (count !== 16'd1) begin n_fail++; $display("FAIL lm_load_count got %0d want 1", count); end
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      n_checks++; if (count !== exp_seq[i]) begin n_fail++; $display("FAIL lm_count i=%0d got %0d want %0d", i, count, exp_seq[i]); end
      n_checks++; if (expire !== exp_ex[i]) begin n_fail++; $display("FAIL lm_expire i=%0d got %b want %b", i, expire, exp_ex[i]); end
    end
  endtask

  task automatic test_clear_expire();
    do_reset();
    periodic  = 1'b0;
    presc_div = 8'd0;
    send_cmd(CMD_LOAD, 16'd1);
    send_cmd(CMD_START, 16'd0);
    cycles(1);
    send_cmd(CMD_CLEAR, 16'd0);
    n_checks++; if (expire !== 1'b1) begin n_fail++; $display("FAIL ce_expire got %b want 1", expire); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ce_irq got %b want 1", irq); end
  endtask

  task automatic test_async_reset();
    do_reset();
    periodic  = 1'b1;
    presc_div = 8'd0;
    send_cmd(CMD_LOAD, 16'd1);
    send_cmd(CMD_START, 16'd0);
    cycles(3);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ar_pre_irq got %b want 1", irq); end
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL ar_pre_tick got %b want 1", tick); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL ar_count got %0d want 0", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b want 0", busy); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL ar_tick got %b want 0", tick); end
    n_checks++; if (expire !== 1'b0) begin n_fail++; $display("FAIL ar_expire got %b want 0", expire); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq got %b want 0", irq); end
    cycles(1);
    reset = 1'b1;
    cycles(1);
  endtask

`ifdef TIMER_CTRL_CAPTURE_EN
  task automatic test_capture();
    do_reset();
    periodic  = 1'b0;
    presc_div = 8'd0;
    send_cmd(CMD_LOAD, 16'd9);
    send_cmd(CMD_START, 16'd0);
    cycles(2);
    n_checks++; if (count !== 16'd7) begin n_fail++; $display("FAIL cap_pre_count got %0d want 7", count); end
    cap_req = 1'b1;
    cycles(1);
    cap_req = 1'b0;
    n_checks++; if (cap_val !== 16'd7) begin n_fail++; $display("FAIL cap_val got %0d want 7", cap_val); end
    n_checks++; if (cap_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid got %b want 1", cap_valid); end
    n_checks++; if (count !== 16'd6) begin n_fail++; $display("FAIL cap_count got %0d want 6", count); end
    cycles(1);
    n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("FAIL cap_valid_drop got %b want 0", cap_valid); end
    n_checks++; if (cap_val !== 16'd7) begin n_fail++; $display("FAIL cap_val_hold got %0d want 7", cap_val); end
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_stop_tick();
    test_load_midrun();
    test_clear_expire();
    test_async_reset();
`ifdef TIMER_CTRL_CAPTURE_EN
    test_capture();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
